// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-hazard definitions: forward-select encodings and the
// scoreboard slot layout used by the hazard unit and the ID stage.
package hazard_ctrl_pkg;

  localparam logic [1:0] FW_RF  = 2'd0;
  localparam logic [1:0] FW_EXE = 2'd1;
  localparam logic [1:0] FW_MEM = 2'd2;
  localparam logic [1:0] FW_WB  = 2'd3;

  localparam int SLOT_W = 8;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       is_load;
  } slot_t;

  // A slot can only feed a source that is actually read, and x0 is never forwarded.
  function automatic logic slot_match(slot_t s, logic [4:0] src, logic src_en);
    return s.valid && s.we && (s.rd != 5'd0) && (s.rd == src) && src_en;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage request bundle and pipeline control outputs of the hazard unit.
interface hazard_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_we;
  logic       id_is_load;
  logic       id_is_branch;
  logic       branch_taken;
  logic       trap;
  logic       mem_stall;
  logic [1:0] ctrl_forwa;
  logic [1:0] ctrl_forwb;
  logic       stall_if;
  logic       stall_id;
  logic       bubble_ex;
  logic       freeze_all;
  logic       flush_id;
  logic [15:0] stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we,
           id_is_load, id_is_branch, branch_taken, trap, mem_stall,
    input  ctrl_forwa, ctrl_forwb, stall_if, stall_id, bubble_ex, freeze_all,
           flush_id, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we,
           id_is_load, id_is_branch, branch_taken, trap, mem_stall,
    output ctrl_forwa, ctrl_forwb, stall_if, stall_id, bubble_ex, freeze_all,
           flush_id, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Three-slot priority matcher for one ID source operand (EX > MEM > WB).
module fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  slot_t      ex,
  input  slot_t      mem,
  input  slot_t      wb,
  input  logic [4:0] src,
  input  logic       src_en,
  output logic [1:0] sel,
  output logic       ex_hit
);

  always_comb begin
    ex_hit = slot_match(ex, src, src_en);
    sel    = FW_RF;
    if (ex_hit)
      sel = FW_EXE;
    else if (slot_match(mem, src, src_en))
      sel = FW_MEM;
    else if (slot_match(wb, src, src_en))
      sel = FW_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: destination scoreboard, operand forwarding,
// load-use/branch interlocks, memory-stall freeze, trap flush, stall counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  slot_t sb_ex, sb_mem, sb_wb;
  slot_t id_slot;
  logic  ex_hit_a, ex_hit_b;
  logic  hazard;
  logic  stall_if, stall_id, bubble_ex, freeze_all, flush_id;
  logic [15:0] stall_cnt;

  fwd_sel u_fwd_a (
    .ex(sb_ex), .mem(sb_mem), .wb(sb_wb),
    .src(hz.id_rs1), .src_en(hz.id_use_rs1),
    .sel(hz.ctrl_forwa), .ex_hit(ex_hit_a)
  );

  fwd_sel u_fwd_b (
    .ex(sb_ex), .mem(sb_mem), .wb(sb_wb),
    .src(hz.id_rs2), .src_en(hz.id_use_rs2),
    .sel(hz.ctrl_forwb), .ex_hit(ex_hit_b)
  );

  // A branch resolved in ID cannot take an EX result even from a non-load.
  assign hazard = (ex_hit_a || ex_hit_b) && (sb_ex.is_load || hz.id_is_branch);

  always_comb begin
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    bubble_ex  = 1'b0;
    freeze_all = 1'b0;
    flush_id   = 1'b0;
    if (hz.trap) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (hz.mem_stall) begin
      freeze_all = 1'b1;
      stall_if   = 1'b1;
      stall_id   = 1'b1;
    end else if (hazard) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (hz.branch_taken && hz.id_valid) begin
      flush_id = 1'b1;
    end
  end

  always_comb begin
    id_slot         = '0;
    id_slot.valid   = hz.id_valid && !bubble_ex;
    id_slot.rd      = hz.id_rd;
    id_slot.we      = hz.id_we;
    id_slot.is_load = hz.id_is_load;
  end

  always_ff @(posedge clk) begin
    if (rst || hz.trap) begin
      sb_ex  <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
    end else if (!freeze_all) begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      sb_ex  <= id_slot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= 16'd0;
    else if (stall_id && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

  assign hz.stall_if   = stall_if;
  assign hz.stall_id   = stall_id;
  assign hz.bubble_ex  = bubble_ex;
  assign hz.freeze_all = freeze_all;
  assign hz.flush_id   = flush_id;
  assign hz.stall_cnt  = stall_cnt;

endmodule
